// File: rtl/sound_ram_ctrl_pkg.sv
// Shared types and constants for the sound RAM record/playback controller.
package sound_pkg;

  localparam int SAMPLE_W = 24;
  localparam int ADDR_W   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

endpackage

// File: rtl/sound_ram_ctrl_if.sv
// Port bundle between the controller and the external synchronous sound RAM.
interface sound_ram_if;
  import sound_pkg::*;

  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_we;
  logic [SAMPLE_W-1:0] ram_din;
  logic [SAMPLE_W-1:0] ram_dout;

  modport master (
    output ram_addr,
    output ram_we,
    output ram_din,
    input  ram_dout
  );

  modport slave (
    input  ram_addr,
    input  ram_we,
    input  ram_din,
    output ram_dout
  );

endinterface

// File: rtl/sound_ram_ctrl.sv
// Record/playback sequencer for an external sound RAM with one-cycle read latency.
module sound_ram_ctrl
  import sound_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rec_start,
    input  logic                play_start,
    input  logic                stop,
    input  logic                loop,
    input  logic                sample_tick,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    sound_ram_if.master         ram,
    output logic [ADDR_W-1:0]   length,
    output logic                busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FULL = ADDR_W'(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              rd_pend;
    logic              play_last;

    assign play_last = (ptr == length - 16'd1);

    // Write strobe follows the tick directly; reset masks a stale RECORD state.
    assign ram.ram_we   = (state == RECORD) && sample_tick && !reset;
    assign ram.ram_addr = ptr;
    assign ram.ram_din  = sample_in;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            length       <= '0;
            rd_pend      <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            rd_pend      <= 1'b0;
            sample_valid <= rd_pend;
            if (rd_pend) begin
                sample_out <= ram.ram_dout;
            end

            unique case (state)
                IDLE: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (rec_start) begin
                        ptr   <= '0;
                        state <= RECORD;
                    end else if (play_start && length != '0) begin
                        ptr   <= '0;
                        state <= PLAY;
                    end
                end

                RECORD: begin
                    if (stop) begin
                        length <= ptr + ADDR_W'(sample_tick);
                        ptr    <= '0;
                        state  <= IDLE;
                    end else if (sample_tick) begin
                        if (ptr == LAST) begin
                            length <= FULL;
                            ptr    <= '0;
                            state  <= IDLE;
                        end else begin
                            ptr <= ptr + 16'd1;
                        end
                    end
                end

                PLAY: begin
                    // A tick in the stop cycle issues no read; one already issued drains.
                    if (stop) begin
                        ptr   <= '0;
                        state <= IDLE;
                    end else if (sample_tick) begin
                        rd_pend <= 1'b1;
                        if (play_last) begin
                            ptr <= '0;
                            if (!loop) begin
                                state <= IDLE;
                            end
                        end else begin
                            ptr <= ptr + 16'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sound_ram_ctrl.md
SOUND_RAM_CTRL -- requirements
Module: sound_ram_ctrl

Interface
REQ-001 Parameter DEPTH, default 64, meaning number of usable sample slots in the attached sound RAM (addresses 0..DEPTH-1).
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rec_start  in  1  single-cycle pulse; begin recording at address 0.
REQ-005 play_start  in  1  single-cycle pulse; begin playback at address 0.
REQ-006 stop  in  1  single-cycle pulse; abort current operation.
REQ-007 loop  in  1  level; when high, playback wraps to 0 instead of ending.
REQ-008 sample_tick  in  1  one-cycle strobe per audio sample period.
REQ-009 sample_in  in  24  audio sample to record, sampled on sample_tick.
REQ-010 sample_out  out  24  registered playback sample.
REQ-011 sample_valid  out  1  one-cycle pulse qualifying sample_out.
REQ-012 ram_addr  out  16  RAM address, equals internal pointer, zero-extended.
REQ-013 ram_we  out  1  RAM write enable.
REQ-014 ram_din  out  24  RAM write data, equals sample_in.
REQ-015 ram_dout  in  24  RAM read data, valid one cycle after address is presented.
REQ-016 length  out  16  number of samples held from the last recording.
REQ-017 busy  out  1  high when state is not IDLE.

Function
REQ-018 The block SHALL implement states IDLE, RECORD, PLAY.
REQ-019 Command priority SHALL be stop > rec_start > play_start when asserted in the same cycle.
REQ-020 In IDLE, rec_start SHALL clear pointer to 0 and enter RECORD next cycle.
REQ-021 In IDLE, play_start with length != 0 SHALL clear pointer to 0 and enter PLAY; with length == 0 it SHALL be ignored.
REQ-022 rec_start and play_start SHALL be ignored outside IDLE.
REQ-023 In RECORD, ram_we SHALL equal sample_tick combinationally; the pointer SHALL increment on each tick.
REQ-024 A tick written at pointer DEPTH-1 SHALL set length to DEPTH and return to IDLE (no wrap, no overwrite).
REQ-025 stop in RECORD SHALL set length to the count of samples written (including a tick in the same cycle) and return to IDLE.
REQ-026 In PLAY, a tick in cycle t SHALL read address pointer; ram_dout is captured into sample_out at end of t+1; sample_valid SHALL be high in cycle t+2 only.
REQ-027 At a PLAY tick with pointer == length-1: loop high -> pointer to 0, stay PLAY; loop low -> return to IDLE.
REQ-028 The read of the final sample SHALL still produce its sample_valid pulse after the return to IDLE.
REQ-029 stop in PLAY SHALL return to IDLE; a read already issued SHALL still complete its sample_valid pulse; a tick in the stop cycle SHALL NOT issue a read.
REQ-030 ram_we SHALL be 0 in every state except RECORD.
REQ-031 length SHALL change only at the end of a recording.

Reset
REQ-032 reset SHALL force: state IDLE, pointer 0, length 0, sample_out 0, sample_valid 0, in-flight read pipeline cleared.
REQ-033 ram_we SHALL be 0 during reset and in the first cycle after it.
REQ-034 Reset mid-RECORD SHALL discard the recording (length 0); reset mid-PLAY SHALL emit no further sample_valid.

Structure
REQ-035 State enum (IDLE, RECORD, PLAY) and the 24-bit sample width constant SHALL live in shared package sound_pkg.
REQ-036 The block SHALL NOT instantiate the RAM; the top level SHALL wire ram_* ports to sound_ram.
REQ-037 No sub-module is required; pointer and read-pipeline registers SHALL be inline.

Verification
REQ-038 Record 5 ticks with sample_in 0x000001..0x000005, then stop -> length 5, RAM addresses 0..4 hold 1..5, busy low.
REQ-039 Play with loop 0 after REQ-038 -> five sample_valid pulses with 1..5, each 2 cycles after its tick, then IDLE.
REQ-040 Record 70 ticks with DEPTH 64 -> ram_we high for exactly 64 ticks, length 64, IDLE after tick 64.
REQ-041 Play 3-sample recording with loop 1 for 7 ticks -> outputs 1,2,3,1,2,3,1, state remains PLAY.
REQ-042 stop, rec_start and play_start in the same IDLE cycle -> no state change; play_start with length 0 -> busy stays low.
REQ-043 reset asserted during RECORD after 3 ticks -> length 0, state IDLE, no sample_valid, ram_we 0 next cycle.
